vacc_readout: RTL and testbench

VACC_READOUT -- requirements
Module: vacc_readout

---
 rtl/xeng_vacc_pkg.sv | 37 +++
 rtl/vacc_rd_fifo.sv | 85 ++++++++
 rtl/vacc_readout.sv | 158 +++++++++++++++
 tb/tb_vacc_readout.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xeng_vacc_pkg.sv
// ---------------------------------------------------------------------------
// xeng_vacc_pkg
// Shared definitions for the vector-accumulator readout path:
//   - vacc_state_t : readout FSM state encoding
//   - FIFO_DEPTH / FIFO_CNT_W : output FIFO geometry
//   - log2c()     : ceiling log2, a constant function that works in any flow
//   - acc_width() : accumulated word width from input width and length bits
// ---------------------------------------------------------------------------
package xeng_vacc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } vacc_state_t;

  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_CNT_W = 3;

  // Ceiling log2 written as a simple loop so it elaborates as a constant
  // function everywhere; log2c(1) = 0, log2c(32) = 5.
  function automatic int log2c(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >>> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Accumulated word width: input sample width plus the growth from
  // summing 2**acc_len_bits samples.
  function automatic int acc_width(input int input_width, input int acc_len_bits);
    return input_width + acc_len_bits;
  endfunction

endpackage

// File: rtl/vacc_rd_fifo.sv
// ---------------------------------------------------------------------------
// vacc_rd_fifo
// Four-entry first-word-fall-through FIFO for readout words. When empty, a
// word being written is presented on the read side in the same cycle; if it
// is consumed right away it is never stored.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   wr_en     : write strobe (caller guarantees no write when full)
//   wr_data   : word to write ({last flag, data})
//   rd_en     : consumer accepts the head word this cycle
//   rd_data   : head word, zero when nothing is available
//   rd_valid  : rd_data holds a word
//   count     : number of stored words (0..4)
// ---------------------------------------------------------------------------
module vacc_rd_fifo
  import xeng_vacc_pkg::*;
#(
  parameter int WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_valid,
  output logic [FIFO_CNT_W-1:0] count
);

  logic [WIDTH-1:0]      mem [FIFO_DEPTH];
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [FIFO_CNT_W-1:0] cnt;
  logic                  empty;
  logic                  bypass;
  logic                  store;
  logic                  take;

  // An empty FIFO passes the incoming word straight through; a stored word
  // is only created when the write is not consumed in the same cycle.
  always_comb begin
    empty    = (cnt == '0);
    bypass   = empty && wr_en && rd_en;
    store    = wr_en && !bypass;
    take     = rd_en && !empty;
    rd_valid = !empty || wr_en;
    if (!empty) begin
      rd_data = mem[rd_ptr];
    end else if (wr_en) begin
      rd_data = wr_data;
    end else begin
      rd_data = '0;
    end
  end

  // Storage array: no reset needed, occupancy is tracked by cnt.
  always_ff @(posedge clk) begin
    if (store) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (store) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (take) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({store, take})
        2'b10:   cnt <= cnt + FIFO_CNT_W'(1);
        2'b01:   cnt <= cnt - FIFO_CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign count = cnt;

endmodule

// File: rtl/vacc_readout.sv
// ---------------------------------------------------------------------------
// vacc_readout
// Reads one completed accumulation buffer out of a dual-buffer BRAM and
// streams its VECTOR_LENGTH words through a ready/valid interface.
// Reads are credit-limited so the 4-deep output FIFO can never overflow,
// whatever the consumer does with dout_ready.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   buf_done      : pulse, buffer buf_done_sel finished accumulating
//   buf_done_sel  : index of the finished buffer
//   ram_addr      : BRAM read address {buffer, word index}, 0 when idle
//   ram_en        : BRAM read enable
//   ram_dout      : BRAM data, valid RD_LATENCY cycles after ram_en
//   dout          : output word (FIFO head)
//   dout_valid    : dout holds a word
//   dout_ready    : consumer accepts the word
//   dout_last     : dout is the final word of the vector
//   busy          : readout in progress
//   overrun       : sticky, buf_done arrived while a readout was running
// ---------------------------------------------------------------------------
module vacc_readout
  import xeng_vacc_pkg::*;
#(
  parameter  int INPUT_WIDTH   = 4,
  parameter  int ACC_LEN_BITS  = 8,
  parameter  int VECTOR_LENGTH = 32,
  parameter  int RD_LATENCY    = 2,
  localparam int ACC_WIDTH     = acc_width(INPUT_WIDTH, ACC_LEN_BITS),
  localparam int VLB           = log2c(VECTOR_LENGTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 buf_done,
  input  logic                 buf_done_sel,
  output logic [VLB:0]         ram_addr,
  output logic                 ram_en,
  input  logic [ACC_WIDTH-1:0] ram_dout,
  output logic [ACC_WIDTH-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 dout_last,
  output logic                 busy,
  output logic                 overrun
);

  vacc_state_t           state;
  vacc_state_t           next_state;
  logic                  sel_q;
  logic [VLB-1:0]        counter;
  logic [RD_LATENCY-1:0] vld;
  logic [RD_LATENCY-1:0] lst;
  logic                  overrun_q;
  logic [7:0]            in_flight;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic                  credit_ok;
  logic                  issue;
  logic                  last_issue;
  logic                  head_last;

  // Words in the BRAM pipeline plus words held in the FIFO must never exceed
  // the FIFO depth, so every issued read is guaranteed a slot on return.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      in_flight = in_flight + 8'(vld[i]);
    end
    credit_ok  = (8'(fifo_count) + in_flight) < 8'(FIFO_DEPTH);
    last_issue = (counter == VLB'(VECTOR_LENGTH - 1));
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next state. A readout can only begin from IDLE; DRAIN waits until the
  // pipeline and FIFO are both empty so busy covers every outstanding word.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (buf_done) begin
          next_state = ST_READ;
        end
      end
      ST_READ: begin
        if (issue && last_issue) begin
          next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((in_flight == '0) && (fifo_count == '0)) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // FSM outputs. The address is forced to zero whenever no read is issued.
  always_comb begin
    busy     = (state != ST_IDLE);
    issue    = (state == ST_READ) && credit_ok;
    ram_en   = issue;
    ram_addr = issue ? {sel_q, counter} : '0;
  end

  // Datapath: buffer select, word counter, return-valid/last pipelines and
  // the sticky overrun flag. Clearing vld on reset is what drops any BRAM
  // data still returning from an abandoned readout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q     <= 1'b0;
      counter   <= '0;
      vld       <= '0;
      lst       <= '0;
      overrun_q <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && buf_done) begin
        sel_q   <= buf_done_sel;
        counter <= '0;
      end else if (issue) begin
        counter <= counter + VLB'(1);
      end
      if (buf_done && (state != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end
      vld[0] <= issue;
      lst[0] <= issue && last_issue;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld[i] <= vld[i-1];
        lst[i] <= lst[i-1];
      end
    end
  end

  assign overrun = overrun_q;

  vacc_rd_fifo #(
    .WIDTH (ACC_WIDTH + 1)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (vld[RD_LATENCY-1]),
    .wr_data  ({lst[RD_LATENCY-1], ram_dout}),
    .rd_en    (dout_ready),
    .rd_data  ({head_last, dout}),
    .rd_valid (dout_valid),
    .count    (fifo_count)
  );

  assign dout_last = dout_valid && head_last;

endmodule

// File: tb/tb_vacc_readout.sv
// ---------------------------------------------------------------------------
// tb_vacc_readout
// Self-checking bench for vacc_readout with default parameters. A latency-2
// BRAM model feeds the DUT; the reference is simply the list of words a
// readout of the chosen buffer must produce, in index order.
// ---------------------------------------------------------------------------
module tb_vacc_readout;

  localparam int AW = 12;
  localparam int VL = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          buf_done;
  logic          buf_done_sel;
  logic [5:0]    ram_addr;
  logic          ram_en;
  logic [AW-1:0] ram_dout;
  logic [AW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          dout_last;
  logic          busy;
  logic          overrun;

  logic [AW-1:0] bram [64];
  logic [AW-1:0] bram_p0;

  int passed = 0;
  int fails  = 0;
  int total  = 0;
  int cyc    = 0;
  int issue_idx, stalls, max_cnt, first_valid, last_valid, words_rx, bd_cyc;
  int ready_mode, phase;
  logic exp_sel;
  logic [AW:0] exp_q [$];
  logic prev_hold;
  logic [AW-1:0] prev_dout;

  vacc_readout dut (
    .clk          (clk),
    .rst          (rst),
    .buf_done     (buf_done),
    .buf_done_sel (buf_done_sel),
    .ram_addr     (ram_addr),
    .ram_en       (ram_en),
    .ram_dout     (ram_dout),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready),
    .dout_last    (dout_last),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // BRAM with output register: address sampled on one edge, data on the
  // port after the next edge.
  always @(posedge clk) begin
    if (ram_en) begin
      bram_p0 <= bram[ram_addr];
    end
    ram_dout <= bram_p0;
  end

  // Hard stop in case something upstream never terminates.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: counts passes and failures and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives the inputs of one clock cycle shortly after the rising edge.
  task automatic applyStimulus(input logic bd, input logic sel);
    @(posedge clk);
    #1;
    buf_done     = bd;
    buf_done_sel = sel;
    case (ready_mode)
      0:       dout_ready = 1'b1;
      1:       dout_ready = ((phase % 4) == 0) || ((phase % 4) == 3);
      default: dout_ready = 1'($urandom_range(0, 1));
    endcase
    phase++;
    cyc++;
  endtask

  // Observes the cycle mid-way: read addresses against the expected sweep,
  // output words against the expected list, and output hold behaviour.
  task automatic sampleCycle();
    logic [AW:0] e;
    #3;
    if (int'(dut.u_fifo.count) > max_cnt) max_cnt = int'(dut.u_fifo.count);
    if (ram_en) begin
      checkOutput("ram_addr", 32'(ram_addr), 32'({exp_sel, 5'(issue_idx)}));
      checkOutput("ram_en_in_range", 32'(issue_idx < VL), 32'd1);
      issue_idx++;
    end else if (busy && issue_idx > 0 && issue_idx < VL) begin
      stalls++;
    end
    if (prev_hold) begin
      checkOutput("hold_valid", 32'(dout_valid), 32'd1);
      checkOutput("hold_data", 32'(dout), 32'(prev_dout));
    end
    if (!dout_valid) begin
      checkOutput("last_without_valid", 32'(dout_last), 32'd0);
    end
    if (dout_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_word", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        checkOutput("dout", 32'(dout), 32'(e[AW-1:0]));
        checkOutput("dout_last", 32'(dout_last), 32'(e[AW]));
        words_rx++;
        if (first_valid < 0) first_valid = cyc;
        last_valid = cyc;
      end
    end
    prev_hold = dout_valid && !dout_ready;
    prev_dout = dout;
  endtask

  task automatic step(input logic bd, input logic sel);
    applyStimulus(bd, sel);
    sampleCycle();
  endtask

  // Queues the expected vector for buffer sel and pulses buf_done.
  task automatic startReadout(input logic sel);
    for (int i = 0; i < VL; i++) begin
      exp_q.push_back({1'(i == VL - 1), bram[{sel, 5'(i)}]});
    end
    exp_sel     = sel;
    issue_idx   = 0;
    first_valid = -1;
    last_valid  = -1;
    words_rx    = 0;
    step(1'b1, sel);
    bd_cyc = cyc;
  endtask

  // Runs until every expected word has arrived and busy has dropped.
  task automatic runUntilIdle(input int max_cycles);
    logic done;
    done = 1'b0;
    for (int n = 0; n < max_cycles && !done; n++) begin
      step(1'b0, 1'b0);
      if (exp_q.size() == 0 && !busy) done = 1'b1;
    end
    checkOutput("readout_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    // Buffer 1 holds 0x100+i; buffer 0 gets random contents.
    for (int i = 0; i < VL; i++) begin
      bram[32 + i] = AW'(12'h100 + i);
      bram[i]      = AW'($urandom);
    end
    bram_p0      = '0;
    rst          = 1'b1;
    buf_done     = 1'b0;
    buf_done_sel = 1'b0;
    dout_ready   = 1'b0;
    ready_mode   = 0;
    phase        = 0;
    stalls       = 0;
    max_cnt      = 0;
    prev_hold    = 1'b0;
    exp_sel      = 1'b0;
    issue_idx    = 0;

    // Reset values while reset is held.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ram_en", 32'(ram_en), 32'd0);
    checkOutput("rst_ram_addr", 32'(ram_addr), 32'd0);
    checkOutput("rst_dout", 32'(dout), 32'd0);
    checkOutput("rst_dout_valid", 32'(dout_valid), 32'd0);
    checkOutput("rst_dout_last", 32'(dout_last), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Full-rate readout of buffer 1: timing of busy and first word, then 32
    // consecutive words.
    $display("[TB] full-rate readout of buffer 1");
    ready_mode = 0;
    startReadout(1'b1);
    checkOutput("busy_in_bd_cycle", 32'(busy), 32'd0);
    step(1'b0, 1'b0);
    checkOutput("busy_after_bd", 32'(busy), 32'd1);
    runUntilIdle(100);
    checkOutput("first_valid_latency", 32'(first_valid - bd_cyc), 32'd3);
    checkOutput("consecutive_words", 32'(last_valid - first_valid), 32'd31);
    checkOutput("words_full_rate", 32'(words_rx), 32'd32);
    checkOutput("overrun_clean", 32'(overrun), 32'd0);

    // Back-pressure with dout_ready cycling 1,0,0,1.
    $display("[TB] back-pressured readout of buffer 1");
    ready_mode = 1;
    phase      = 0;
    stalls     = 0;
    max_cnt    = 0;
    startReadout(1'b1);
    runUntilIdle(300);
    checkOutput("words_backpressure", 32'(words_rx), 32'd32);
    checkOutput("ram_en_stall_seen", 32'(stalls > 0), 32'd1);
    checkOutput("fifo_count_max", 32'(max_cnt <= 4), 32'd1);

    // buf_done during a readout: flagged, otherwise ignored.
    $display("[TB] buf_done during readout");
    ready_mode = 0;
    startReadout(1'b1);
    for (int n = 0; n < 50 && issue_idx < 10; n++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    checkOutput("overrun_set", 32'(overrun), 32'd1);
    runUntilIdle(100);
    checkOutput("words_overrun", 32'(words_rx), 32'd32);
    repeat (10) step(1'b0, 1'b0);
    checkOutput("no_second_readout", 32'(busy), 32'd0);
    checkOutput("overrun_sticky", 32'(overrun), 32'd1);

    // Reset in the middle of a readout with reads outstanding.
    $display("[TB] reset mid-readout");
    startReadout(1'b1);
    for (int n = 0; n < 50 && issue_idx < 15; n++) step(1'b0, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_ram_en", 32'(ram_en), 32'd0);
    checkOutput("mid_rst_ram_addr", 32'(ram_addr), 32'd0);
    checkOutput("mid_rst_dout", 32'(dout), 32'd0);
    checkOutput("mid_rst_dout_valid", 32'(dout_valid), 32'd0);
    checkOutput("mid_rst_dout_last", 32'(dout_last), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_overrun", 32'(overrun), 32'd0);
    exp_q.delete();
    prev_hold = 1'b0;
    issue_idx = VL;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) step(1'b0, 1'b0);
    checkOutput("idle_after_rst", 32'(busy), 32'd0);

    // Fresh readout of random buffer 0 with random back-pressure.
    ready_mode = 2;
    startReadout(1'b0);
    runUntilIdle(400);
    checkOutput("words_buffer0", 32'(words_rx), 32'd32);

    // Back-to-back readouts: the second buf_done lands just after busy falls.
    $display("[TB] back-to-back readouts");
    ready_mode = 0;
    startReadout(1'b1);
    runUntilIdle(100);
    checkOutput("words_b2b_first", 32'(words_rx), 32'd32);
    startReadout(1'b0);
    runUntilIdle(100);
    checkOutput("words_b2b_second", 32'(words_rx), 32'd32);
    checkOutput("overrun_b2b", 32'(overrun), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
